clint_timer: RTL and testbench

CLINT_TIMER -- requirements
Module: clint_timer

---
 rtl/clint_timer.sv | 179 +++++++++++++++++
 tb/tb_clint_timer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer: machine timer / software interrupt block (CLINT subset).
//
// Build option:
//   CLINT_MSIP_EN  defined   -> msip register at offset 0x00, drives
//                               software_interrupt_o.
//                  undefined -> no msip storage, offset 0x00 reads 0,
//                               software_interrupt_o tied low.
//
// Parameters:
//   TICK_DIV  clk_i cycles per mtime increment (1..65535).
//
// Ports:
//   clk_i                 clock, all state on rising edge
//   rst_i                 synchronous active-high reset
//   we_i / re_i           bus write / read strobes
//   addr_i                byte address, only [4:0] decoded
//   wdata_i               write data
//   rdata_o               registered read data (valid in ack cycle)
//   ack_o                 one-cycle acknowledge following each strobe
//   timer_interrupt_o     level: mtime >= mtimecmp (unsigned)
//   software_interrupt_o  msip[0]
//
// Register map (addr_i[4:0]):
//   0x00 msip[0]   0x08 mtimecmp lo   0x0C mtimecmp hi
//   0x10 mtime lo  0x14 mtime hi      others read 0, writes ignored
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic                   re_i,
  input  logic [`ADDR_WIDTH-1:0] addr_i,
  input  logic [`DATA_WIDTH-1:0] wdata_i,
  output logic [`DATA_WIDTH-1:0] rdata_o,
  output logic                   ack_o,
  output logic                   timer_interrupt_o,
  output logic                   software_interrupt_o
);

  localparam int unsigned ADDR_W  = `ADDR_WIDTH;
  localparam int unsigned DATA_W  = `DATA_WIDTH;
  localparam int unsigned TIME_W  = 64;
  localparam int unsigned HALF_W  = 32;
  localparam int unsigned PRESC_W = 16;
  localparam int unsigned OFF_W   = 5;

  localparam logic [OFF_W-1:0] OFF_MSIP     = 5'h00;
  localparam logic [OFF_W-1:0] OFF_MTCMP_LO = 5'h08;
  localparam logic [OFF_W-1:0] OFF_MTCMP_HI = 5'h0C;
  localparam logic [OFF_W-1:0] OFF_MTIME_LO = 5'h10;
  localparam logic [OFF_W-1:0] OFF_MTIME_HI = 5'h14;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [TIME_W-1:0]  mtime_q,    mtime_d;
  logic [TIME_W-1:0]  mtimecmp_q, mtimecmp_d;
  logic [PRESC_W-1:0] presc_q,    presc_d;
  logic [DATA_W-1:0]  rdata_q,    rdata_d;
  logic               ack_q,      ack_d;

  logic [OFF_W-1:0]   off_c;
  logic [DATA_W-1:0]  rd_val_c;
  logic               tick_c;

  // Upper address bits are outside the decoded window.
  logic unused_addr;
  assign unused_addr = ^addr_i[ADDR_W-1:OFF_W];

  assign off_c  = addr_i[OFF_W-1:0];
  assign tick_c = (presc_q == PRESC_LAST);

`ifdef CLINT_MSIP_EN
  logic msip_q, msip_d;

  // msip register: only bit 0 is stored.
  always_comb begin
    msip_d = msip_q;
    if (we_i && (off_c == OFF_MSIP)) begin
      msip_d = wdata_i[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msip_q <= 1'b0;
    end else begin
      msip_q <= msip_d;
    end
  end

  assign software_interrupt_o = msip_q;
`else
  logic msip_q;
  assign msip_q               = 1'b0;
  assign software_interrupt_o = 1'b0;
`endif

  // Read mux over current register values (pre-write on a combined access).
  always_comb begin
    rd_val_c = '0;
    unique case (off_c)
      OFF_MSIP:     rd_val_c = DATA_W'(msip_q);
      OFF_MTCMP_LO: rd_val_c = DATA_W'(mtimecmp_q[HALF_W-1:0]);
      OFF_MTCMP_HI: rd_val_c = DATA_W'(mtimecmp_q[TIME_W-1:HALF_W]);
      OFF_MTIME_LO: rd_val_c = DATA_W'(mtime_q[HALF_W-1:0]);
      OFF_MTIME_HI: rd_val_c = DATA_W'(mtime_q[TIME_W-1:HALF_W]);
      default:      rd_val_c = '0;
    endcase
  end

  // mtime / prescaler: a software write to either half wins over the tick
  // and restarts the prescaler so the new value is held a full period.
  always_comb begin
    mtime_d = mtime_q;
    presc_d = presc_q;
    if (we_i && (off_c == OFF_MTIME_LO)) begin
      mtime_d[HALF_W-1:0] = HALF_W'(wdata_i);
      presc_d             = '0;
    end else if (we_i && (off_c == OFF_MTIME_HI)) begin
      mtime_d[TIME_W-1:HALF_W] = HALF_W'(wdata_i);
      presc_d                  = '0;
    end else if (tick_c) begin
      mtime_d = mtime_q + TIME_W'(1);
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // mtimecmp halves.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (we_i && (off_c == OFF_MTCMP_LO)) begin
      mtimecmp_d[HALF_W-1:0] = HALF_W'(wdata_i);
    end else if (we_i && (off_c == OFF_MTCMP_HI)) begin
      mtimecmp_d[TIME_W-1:HALF_W] = HALF_W'(wdata_i);
    end
  end

  // Bus response: ack every strobe, capture read data only on reads.
  always_comb begin
    ack_d   = we_i | re_i;
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = rd_val_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
    end
  end

  assign rdata_o           = rdata_q;
  assign ack_o             = ack_q;
  assign timer_interrupt_o = (mtime_q >= mtimecmp_q);

endmodule

// File: tb/tb_clint_timer.sv
// -----------------------------------------------------------------------------
// tb_clint_timer: directed bench for clint_timer. Two instances share one
// bus: u_div1 (TICK_DIV=1) and u_div4 (TICK_DIV=4). Inputs change on the
// falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_clint_timer;

  localparam int unsigned AW = `ADDR_WIDTH;
  localparam int unsigned DW = `DATA_WIDTH;
`ifdef CLINT_MSIP_EN
  localparam bit MSIP_ON = 1'b1;
`else
  localparam bit MSIP_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          we;
  logic          re;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata1, rdata4;
  logic          ack1, ack4;
  logic          tint1, tint4;
  logic          sint1, sint4;

  int n_cmp = 0;
  int n_err = 0;

  clint_timer #(.TICK_DIV(1)) u_div1 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .re_i(re), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata1), .ack_o(ack1),
    .timer_interrupt_o(tint1), .software_interrupt_o(sint1)
  );

  clint_timer #(.TICK_DIV(4)) u_div4 (
    .clk_i(clk), .rst_i(rst), .we_i(we), .re_i(re), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata4), .ack_o(ack4),
    .timer_interrupt_o(tint4), .software_interrupt_o(sint4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One strobe cycle; called and returns on a falling edge.
  task automatic xfer(input logic w, input logic r, input logic [4:0] off,
                      input logic [31:0] d);
    we    = w;
    re    = r;
    addr  = {{(AW-5){1'b1}}, off};
    wdata = DW'(d);
    @(negedge clk);
    we    = 1'b0;
    re    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ack",   64'(ack1),   64'(0));
    check_eq("rst_rdata", 64'(rdata1), 64'(0));
    check_eq("rst_tint1", 64'(tint1),  64'(0));
    check_eq("rst_tint4", 64'(tint4),  64'(0));
    check_eq("rst_sint",  64'(sint1),  64'(0));
    rst = 1'b0;

    // Ten idle edges: div1 mtime=10, div4 mtime=2.
    repeat (10) @(negedge clk);
    check_eq("idle_tint", 64'(tint1), 64'(0));
    xfer(1'b0, 1'b1, 5'h10, 32'h0);
    check_eq("rd_ack1",     64'(ack1),   64'(1));
    check_eq("rd_ack4",     64'(ack4),   64'(1));
    check_eq("mtime_div1",  64'(rdata1), 64'(10));
    check_eq("mtime_div4",  64'(rdata4), 64'(2));
    xfer(1'b0, 1'b1, 5'h08, 32'h0);
    check_eq("cmp_lo_rst",  64'(rdata1), 64'hFFFF_FFFF);
    @(negedge clk);
    check_eq("ack_idle",    64'(ack1),   64'(0));
    check_eq("rdata_hold",  64'(rdata1), 64'hFFFF_FFFF);
    xfer(1'b0, 1'b1, 5'h0C, 32'h0);
    check_eq("cmp_hi_rst",  64'(rdata1), 64'hFFFF_FFFF);
    xfer(1'b0, 1'b1, 5'h14, 32'h0);
    check_eq("mtime_hi0",   64'(rdata1), 64'(0));
    xfer(1'b0, 1'b1, 5'h04, 32'h0);
    check_eq("unmap_04",    64'(rdata1), 64'(0));
    xfer(1'b0, 1'b1, 5'h1C, 32'h0);
    check_eq("unmap_1c",    64'(rdata1), 64'(0));

    // Combined write+read returns the pre-write value.
    xfer(1'b1, 1'b1, 5'h08, 32'h55);
    check_eq("wr_rd_old",   64'(rdata1), 64'hFFFF_FFFF);
    check_eq("wr_rd_ack",   64'(ack1),   64'(1));
    xfer(1'b0, 1'b1, 5'h08, 32'h0);
    check_eq("wr_rd_new",   64'(rdata1), 64'h55);
    check_eq("tint_55",     64'(tint1),  64'(0));

    // Carry from low into high half.
    xfer(1'b1, 1'b0, 5'h10, 32'hFFFF_FFFF);
    check_eq("wr_ack",      64'(ack1),   64'(1));
    @(negedge clk);
    xfer(1'b0, 1'b1, 5'h10, 32'h0);
    check_eq("carry_lo",    64'(rdata1), 64'(0));
    xfer(1'b0, 1'b1, 5'h14, 32'h0);
    check_eq("carry_hi",    64'(rdata1), 64'(1));

    // Full 64-bit wrap; interrupt follows mtime back below mtimecmp.
    xfer(1'b1, 1'b0, 5'h14, 32'hFFFF_FFFF);
    check_eq("tint_hi_only", 64'(tint1), 64'(0));
    xfer(1'b1, 1'b0, 5'h10, 32'hFFFF_FFFF);
    check_eq("tint_max",    64'(tint1),  64'(1));
    @(negedge clk);
    check_eq("tint_wrap",   64'(tint1),  64'(0));
    xfer(1'b0, 1'b1, 5'h10, 32'h0);
    check_eq("wrap_lo",     64'(rdata1), 64'(0));
    xfer(1'b0, 1'b1, 5'h14, 32'h0);
    check_eq("wrap_hi",     64'(rdata1), 64'(0));

    // TICK_DIV=4: mtime restarted at 0, mtimecmp=8 -> rises 32 edges later.
    xfer(1'b1, 1'b0, 5'h14, 32'h0);
    xfer(1'b1, 1'b0, 5'h10, 32'h0);
    xfer(1'b1, 1'b0, 5'h08, 32'h8);
    xfer(1'b1, 1'b0, 5'h0C, 32'h0);
    check_eq("d4_tint_start", 64'(tint4), 64'(0));
    repeat (29) @(negedge clk);
    check_eq("d4_tint_m7",  64'(tint4),  64'(0));
    @(negedge clk);
    check_eq("d4_tint_m8",  64'(tint4),  64'(1));
    repeat (5) @(negedge clk);
    check_eq("d4_tint_lvl", 64'(tint4),  64'(1));
    check_eq("d1_tint_lvl", 64'(tint1),  64'(1));
    xfer(1'b0, 1'b1, 5'h10, 32'h0);
    check_eq("d4_mtime9",   64'(rdata4), 64'(9));

    // Raising mtimecmp above mtime clears the level.
    xfer(1'b1, 1'b0, 5'h08, 32'h100);
    check_eq("d4_tint_clr", 64'(tint4),  64'(0));
    check_eq("d1_tint_clr", 64'(tint1),  64'(0));

    // msip.
    xfer(1'b1, 1'b0, 5'h00, 32'h1);
    check_eq("sint_set",    64'(sint1),  64'(MSIP_ON));
    xfer(1'b0, 1'b1, 5'h00, 32'h0);
    check_eq("msip_rd1",    64'(rdata1), 64'(MSIP_ON));
    xfer(1'b1, 1'b0, 5'h00, 32'hFFFF_FFFF);
    xfer(1'b0, 1'b1, 5'h00, 32'h0);
    check_eq("msip_rd_hi0", 64'(rdata1), 64'(MSIP_ON));
    xfer(1'b1, 1'b0, 5'h00, 32'h0);
    check_eq("sint_clr",    64'(sint1),  64'(0));
    xfer(1'b1, 1'b0, 5'h00, 32'h1);
    check_eq("sint_set2",   64'(sint4),  64'(MSIP_ON));

    // Unmapped write: acked, no effect.
    xfer(1'b1, 1'b0, 5'h18, 32'hDEAD);
    check_eq("unmap_wr_ack", 64'(ack1),  64'(1));
    xfer(1'b0, 1'b1, 5'h18, 32'h0);
    check_eq("unmap_rd",    64'(rdata1), 64'(0));
    xfer(1'b0, 1'b1, 5'h08, 32'h0);
    check_eq("cmp_kept",    64'(rdata1), 64'h100);

    // Force timer pending, then reset with a colliding access.
    xfer(1'b1, 1'b0, 5'h14, 32'h1);
    check_eq("pre_rst_t1",  64'(tint1),  64'(1));
    check_eq("pre_rst_t4",  64'(tint4),  64'(1));
    xfer(1'b0, 1'b1, 5'h14, 32'h0);
    check_eq("pre_rst_rd",  64'(rdata1), 64'(1));
    rst = 1'b1; we = 1'b1; re = 1'b1;
    addr = {{(AW-5){1'b1}}, 5'h10}; wdata = DW'(32'h5);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; re = 1'b0; wdata = '0;
    check_eq("rst_drop_ack", 64'(ack1),  64'(0));
    check_eq("rst_rdata0",  64'(rdata1), 64'(0));
    check_eq("rst_tint1b",  64'(tint1),  64'(0));
    check_eq("rst_tint4b",  64'(tint4),  64'(0));
    check_eq("rst_sint1b",  64'(sint1),  64'(0));
    check_eq("rst_sint4b",  64'(sint4),  64'(0));
    xfer(1'b0, 1'b1, 5'h10, 32'h0);
    check_eq("rst_mtime1",  64'(rdata1), 64'(0));
    check_eq("rst_mtime4",  64'(rdata4), 64'(0));
    xfer(1'b0, 1'b1, 5'h08, 32'h0);
    check_eq("rst_cmp_lo",  64'(rdata1), 64'hFFFF_FFFF);
    xfer(1'b0, 1'b1, 5'h0C, 32'h0);
    check_eq("rst_cmp_hi",  64'(rdata1), 64'hFFFF_FFFF);
    xfer(1'b0, 1'b1, 5'h00, 32'h0);
    check_eq("rst_msip",    64'(rdata1), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
